map9_arbiter: RTL and testbench

- Round-robin scheduler sharing one map9v3 LFSR/counter core between NUM_REQ requesters.
- Accepts a 4-bit N per request, generates the core's edge-detected start pulse, and waits for the core's done edge.
- Returns the core's dp result to the granted requester with a valid/ready response; a watchdog flags a hung core.
- Sits between the requester fabric and a single map9v3 instance, one level above it.

---
 rtl/map9_pkg.sv | 33 +++
 rtl/map9_arbiter_rr_picker.sv | 45 ++++
 rtl/map9_arbiter.sv | 176 +++++++++++++++++
 tb/tb_map9_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/map9_pkg.sv
// map9_pkg
// Shared definitions for the map9v3 request arbiter: the scheduler state
// encoding, the core operand/result widths, default timing parameters and a
// small modular-increment helper used by the round-robin pointer.
// No ports (package).

package map9_pkg;

    // Scheduler states, in the order a request moves through them.
    typedef enum logic [2:0] {
        IDLE,
        START,
        ACK,
        RUN,
        RESP
    } state_t;

    // Widths of the map9v3 core N operand and dp result.
    localparam int N_W  = 4;
    localparam int DP_W = 4;

    // Default timing: the core double-registers and edge-detects start, so
    // the pulse must survive at least two of its samples.
    localparam int DEF_START_HOLD = 3;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_TW         = 8;

    // Returns (v + 1) mod n without a divider.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/map9_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin first-one finder. Starting at index ptr and
// wrapping, it selects the first asserted request.
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   IW       index with highest priority this cycle
//   onehot out  NUM_REQ  one-hot selection (all zero when no request)
//   idx    out  IW       binary index of the selection
//   any    out  1        at least one request is asserted

module rr_picker
    import map9_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IW-1:0]      idx,
    output logic               any
);

    // Walk the requesters in priority order starting at ptr; the first hit
    // wins and later hits are masked by 'any'.
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/map9_arbiter.sv
// map9_arbiter
// Round-robin scheduler sharing one map9v3 core between NUM_REQ requesters.
// One request is in flight at a time: grant, pulse core start, wait for the
// core to clear and then raise done, and return dp through a valid/ready
// response. A watchdog turns a hung core into an error response.
// Ports:
//   clock       in   1          rising-edge clock
//   reset       in   1          asynchronous, active-low reset
//   req         in   NUM_REQ    per-requester request, held until granted
//   req_n       in   4*NUM_REQ  per-requester N operand (slice i for req[i])
//   gnt         out  NUM_REQ    one-hot 1-cycle grant pulse
//   rsp_valid   out  1          response available
//   rsp_ready   in   1          response consumer ready
//   rsp_id      out  clog2(NUM_REQ) requester owning the response
//   rsp_dp      out  4          core dp result (0 on error)
//   rsp_err     out  1          watchdog timeout
//   busy        out  1          high outside IDLE
//   core_start  out  1          to core start
//   core_n      out  4          to core N
//   core_done   in   1          from core done (level)
//   core_dp     in   4          from core dp

module map9_arbiter
    import map9_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int START_HOLD = DEF_START_HOLD,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int TW         = DEF_TW
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [N_W*NUM_REQ-1:0]     req_n,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [DP_W-1:0]            rsp_dp,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       core_start,
    output logic [N_W-1:0]             core_n,
    input  logic                       core_done,
    input  logic [DP_W-1:0]            core_dp
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(START_HOLD) + 1;

    state_t             state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      cur_id;
    logic [TW-1:0]      wdog;
    logic [HW-1:0]      hold_cnt;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               wd_expired;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // The watchdog starts at 0 on the first START cycle, so the cycle in
    // which it reads TIMEOUT-1 is the TIMEOUT-th cycle since start.
    assign wd_expired = (wdog == TW'(TIMEOUT - 1));

    // Single scheduler FSM; every output is a register updated here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            wdog       <= '0;
            hold_cnt   <= '0;
            gnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_dp     <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            core_start <= 1'b0;
            core_n     <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt        <= pick_onehot;
                        core_n     <= req_n[int'(pick_idx)*N_W +: N_W];
                        cur_id     <= pick_idx;
                        rr_ptr     <= IW'(wrap_inc(int'(pick_idx), NUM_REQ));
                        core_start <= 1'b1;
                        hold_cnt   <= '0;
                        wdog       <= '0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end

                START: begin
                    wdog <= wdog + TW'(1);
                    if (wd_expired) begin
                        core_start <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_id     <= cur_id;
                        rsp_dp     <= '0;
                        rsp_err    <= 1'b1;
                        state      <= RESP;
                    end else if (hold_cnt == HW'(START_HOLD - 1)) begin
                        core_start <= 1'b0;
                        state      <= ACK;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end

                // done still high here is left over from the previous run;
                // it must drop before a new done can be trusted.
                ACK: begin
                    wdog <= wdog + TW'(1);
                    if (wd_expired) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_dp    <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end else if (!core_done) begin
                        state <= RUN;
                    end
                end

                // done is tested ahead of the watchdog so a simultaneous
                // arrival still returns a good result.
                RUN: begin
                    wdog <= wdog + TW'(1);
                    if (core_done) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_dp    <= core_dp;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else if (wd_expired) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= cur_id;
                        rsp_dp    <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map9_arbiter.sv
// tb_map9_arbiter
// Directed, table-driven bench for map9_arbiter with a behavioural map9v3
// core model: done clears two cycles after the start edge and rises again a
// programmable number of cycles after it, or sticks high to hang the core.

module tb_map9_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_n;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_dp;
    logic        rsp_err;
    logic        busy;
    logic        core_start;
    logic [3:0]  core_n;
    logic        core_done = 1'b0;
    logic [3:0]  core_dp   = 4'h0;

    // Core model configuration, written by the stimulus code.
    int          delay_cfg = 0;
    logic [3:0]  dp_cfg    = 4'h0;
    bit          stuck     = 1'b0;

    logic        start_q   = 1'b0;
    int          cnt       = 0;
    bit          running   = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] req_n;
        int          delay;
        logic [3:0]  dp;
        bit          stuck;
        int          rw;
        int          exp_id;
        logic [3:0]  exp_n;
        logic [3:0]  exp_dp;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    map9_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_n      (req_n),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_dp     (rsp_dp),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .core_start (core_start),
        .core_n     (core_n),
        .core_done  (core_done),
        .core_dp    (core_dp)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural core: edge-detect start, clear done two cycles later, then
    // raise done with the configured dp once delay_cfg cycles have elapsed.
    always @(posedge clock) begin
        start_q <= core_start;
        if (core_start && !start_q) begin
            cnt     <= 0;
            running <= 1'b1;
        end else if (running) begin
            cnt <= cnt + 1;
            if (cnt == 1 && !stuck) core_done <= 1'b0;
            if (cnt + 1 == delay_cfg) begin
                core_done <= 1'b1;
                core_dp   <= dp_cfg;
                running   <= 1'b0;
            end
        end
        if (stuck) core_done <= 1'b1;
    end

    function automatic vec_t mk(input logic [3:0] r, input logic [15:0] n,
                                input int d, input logic [3:0] dp, input bit st,
                                input int rw, input int id, input logic [3:0] en,
                                input logic [3:0] edp, input bit eerr, input int lat);
        vec_t v;
        v.req = r; v.req_n = n; v.delay = d; v.dp = dp; v.stuck = st; v.rw = rw;
        v.exp_id = id; v.exp_n = en; v.exp_dp = edp; v.exp_err = eerr; v.exp_lat = lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, int'(gnt), 0);
        checkOutput({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        checkOutput({tag, "_rsp_id"}, int'(rsp_id), 0);
        checkOutput({tag, "_rsp_dp"}, int'(rsp_dp), 0);
        checkOutput({tag, "_rsp_err"}, int'(rsp_err), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_core_start"}, int'(core_start), 0);
        checkOutput({tag, "_core_n"}, int'(core_n), 0);
    endtask

    // Configure the core model with requests dropped for one cycle, then
    // present the vector's requests at a falling edge.
    task automatic applyStimulus(input vec_t v);
        req       = 4'b0000;
        stuck     = v.stuck;
        delay_cfg = v.delay;
        dp_cfg    = v.dp;
        rsp_ready = (v.rw == 0);
        @(negedge clock);
        req   = v.req;
        req_n = v.req_n;
    endtask

    // Run one vector end to end: grant, start pulse width, latency,
    // response fields, optional backpressure and the final handshake.
    task automatic runVector(input int i, input vec_t v);
        int  starts;
        int  extra;
        int  lat;
        int  bad;
        bit  got;
        string tag;
        tag    = $sformatf("v%0d", i);
        starts = 0;
        extra  = 0;
        lat    = 0;
        bad    = 0;
        got    = 1'b0;
        applyStimulus(v);
        @(negedge clock);
        checkOutput({tag, "_gnt"}, int'(gnt), 1 << v.exp_id);
        checkOutput({tag, "_core_n"}, int'(core_n), int'(v.exp_n));
        if (core_start) starts++;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            if (core_start) starts++;
            if (gnt != 4'b0000) extra++;
            if (rsp_valid) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_rsp_seen"}, int'(got), 1);
        if (!got) return;
        checkOutput({tag, "_start_cycles"}, starts, 3);
        checkOutput({tag, "_extra_gnt"}, extra, 0);
        checkOutput({tag, "_latency"}, lat, v.exp_lat);
        checkOutput({tag, "_rsp_id"}, int'(rsp_id), v.exp_id);
        checkOutput({tag, "_rsp_dp"}, int'(rsp_dp), int'(v.exp_dp));
        checkOutput({tag, "_rsp_err"}, int'(rsp_err), int'(v.exp_err));
        for (int k = 1; k < v.rw; k++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_id != 2'(v.exp_id) || rsp_dp != v.exp_dp ||
                rsp_err != v.exp_err || gnt != 4'b0000) bad++;
        end
        if (v.rw > 0) begin
            checkOutput({tag, "_backpressure_stable"}, bad, 0);
            rsp_ready = 1'b1;
        end
        @(negedge clock);
        checkOutput({tag, "_valid_after_hs"}, int'(rsp_valid), 0);
        checkOutput({tag, "_busy_after_hs"}, int'(busy), 0);
    endtask

    initial begin
        int  lat;
        bit  got;

        //            req      req_n     d    dp    st rw id n     edp   err lat
        vecs[0]  = mk(4'b0100, 16'h0900, 12,  4'hA, 0, 0, 2, 4'h9, 4'hA, 0, 14);
        vecs[1]  = mk(4'b1000, 16'h7000, 5,   4'h3, 0, 0, 3, 4'h7, 4'h3, 0, 7);
        vecs[2]  = mk(4'b1111, 16'h4321, 4,   4'h1, 0, 0, 0, 4'h1, 4'h1, 0, 6);
        vecs[3]  = mk(4'b1111, 16'h4321, 6,   4'h2, 0, 5, 1, 4'h2, 4'h2, 0, 8);
        vecs[4]  = mk(4'b1111, 16'h4321, 8,   4'h3, 0, 0, 2, 4'h3, 4'h3, 0, 10);
        vecs[5]  = mk(4'b1111, 16'h4321, 10,  4'h4, 0, 0, 3, 4'h4, 4'h4, 0, 12);
        vecs[6]  = mk(4'b1111, 16'h4321, 4,   4'h5, 0, 0, 0, 4'h1, 4'h5, 0, 6);
        vecs[7]  = mk(4'b0010, 16'h00B0, 0,   4'h7, 1, 0, 1, 4'hB, 4'h0, 1, 255);
        vecs[8]  = mk(4'b0001, 16'h000C, 7,   4'h6, 0, 0, 0, 4'hC, 4'h6, 0, 9);
        vecs[9]  = mk(4'b0100, 16'h0D00, 253, 4'hE, 0, 0, 2, 4'hD, 4'hE, 0, 255);
        vecs[10] = mk(4'b1000, 16'hF000, 254, 4'h8, 0, 0, 3, 4'hF, 4'h0, 1, 255);
        vecs[11] = mk(4'b0001, 16'h0005, 3,   4'h9, 0, 0, 0, 4'h5, 4'h9, 0, 5);

        req       = 4'b0000;
        req_n     = 16'h0000;
        rsp_ready = 1'b1;
        reset     = 1'b1;
        #2 reset  = 1'b0;
        repeat (3) @(negedge clock);
        checkAllZero("reset");
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 12; i++) begin
            runVector(i, vecs[i]);
        end

        // Asynchronous reset while the core is running.
        req       = 4'b0000;
        stuck     = 1'b0;
        delay_cfg = 30;
        dp_cfg    = 4'h2;
        rsp_ready = 1'b1;
        @(negedge clock);
        req   = 4'b0100;
        req_n = 16'h0800;
        @(negedge clock);
        checkOutput("ar_gnt", int'(gnt), 4);
        repeat (8) @(negedge clock);
        checkOutput("ar_busy_before", int'(busy), 1);
        #2 reset = 1'b0;
        #1 checkAllZero("async_reset");
        req       = 4'b1010;
        req_n     = 16'h0060;
        delay_cfg = 4;
        dp_cfg    = 4'h3;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("ar_regrant", int'(gnt), 2);
        checkOutput("ar_core_n", int'(core_n), 6);
        req = 4'b0000;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clock);
            if (rsp_valid) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        checkOutput("ar_rsp_seen", int'(got), 1);
        if (got) begin
            checkOutput("ar_latency", lat, 6);
            checkOutput("ar_rsp_id", int'(rsp_id), 1);
            checkOutput("ar_rsp_dp", int'(rsp_dp), 3);
            checkOutput("ar_rsp_err", int'(rsp_err), 0);
        end
        repeat (2) @(negedge clock);
        checkOutput("ar_idle_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
